// File: rtl/imem_loader.sv
// Boot loader for the 256 x 16 instruction memory: parses framed byte stream,
// writes one word per frame slot and holds the CPU in reset until a good frame lands.
module imem_loader #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StWrite,
        StChk,
        StDone,
        StErr
    } loaderState;

    localparam logic [7:0]  SyncByte = 8'hA5;
    localparam logic [31:0] TmoLast  = TIMEOUT - 32'd1;

    loaderState  state;
    loaderState  stateNext;
    logic [7:0]  wordCount;
    logic [7:0]  checksum;
    logic [8:0]  wordCnt;
    logic [7:0]  addr;
    logic [7:0]  hiByte;
    logic [31:0] tmoCnt;

    logic accept;
    logic tmoArmed;
    logic tmoHit;
    logic lastWord;

    assign accept   = in_valid && in_ready;
    assign tmoArmed = (state == StCount) || (state == StHi) || (state == StLo) ||
                      (state == StChk);
    // An accepted byte on the expiry edge wins over the timeout.
    assign tmoHit   = (TIMEOUT != 0) && tmoArmed && !accept && (tmoCnt == TmoLast);
    // 9-bit counter compare so a 256-word frame (count 0xFF) terminates.
    assign lastWord = (wordCnt == {1'b0, wordCount});

    always_comb begin
        stateNext = state;
        unique case (state)
            StIdle, StDone, StErr: begin
                if (accept && in_data == SyncByte) stateNext = StCount;
            end
            StCount: begin
                if (accept)      stateNext = StHi;
                else if (tmoHit) stateNext = StErr;
            end
            StHi: begin
                if (accept)      stateNext = StLo;
                else if (tmoHit) stateNext = StErr;
            end
            StLo: begin
                if (accept)      stateNext = StWrite;
                else if (tmoHit) stateNext = StErr;
            end
            StWrite: begin
                stateNext = lastWord ? StChk : StHi;
            end
            StChk: begin
                if (accept)      stateNext = (in_data == checksum) ? StDone : StErr;
                else if (tmoHit) stateNext = StErr;
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 16'd0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wordCount <= 8'd0;
            checksum  <= 8'd0;
            wordCnt   <= 9'd0;
            addr      <= 8'd0;
            hiByte    <= 8'd0;
            tmoCnt    <= 32'd0;
        end else begin
            state    <= stateNext;
            in_ready <= (stateNext != StWrite);
            busy     <= (stateNext == StCount) || (stateNext == StHi) ||
                        (stateNext == StLo) || (stateNext == StWrite) ||
                        (stateNext == StChk);
            wr_en    <= 1'b0;

            if (accept || !tmoArmed || tmoHit) begin
                tmoCnt <= 32'd0;
            end else begin
                tmoCnt <= tmoCnt + 32'd1;
            end

            unique case (state)
                StIdle, StDone, StErr: begin
                    if (accept && in_data == SyncByte) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                StCount: begin
                    if (accept) begin
                        wordCount <= in_data;
                        checksum  <= in_data;
                        wordCnt   <= 9'd0;
                        addr      <= 8'd0;
                    end else if (tmoHit) begin
                        error <= 1'b1;
                    end
                end
                StHi: begin
                    if (accept) begin
                        hiByte   <= in_data;
                        checksum <= checksum ^ in_data;
                    end else if (tmoHit) begin
                        error <= 1'b1;
                    end
                end
                StLo: begin
                    if (accept) begin
                        checksum <= checksum ^ in_data;
                        wr_data  <= {hiByte, in_data};
                        wr_addr  <= addr;
                        wr_en    <= 1'b1;
                    end else if (tmoHit) begin
                        error <= 1'b1;
                    end
                end
                StWrite: begin
                    addr    <= addr + 8'd1;
                    wordCnt <= wordCnt + 9'd1;
                end
                StChk: begin
                    if (accept) begin
                        if (in_data == checksum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end else if (tmoHit) begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the CPU's 16-bit-wide, 256-entry instruction memory, filling the write side of the array that the fetch stage reads. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and issues one registered write per word. It holds the CPU in reset (`cpu_hold`) until a frame with a matching checksum has been loaded.

## Interface
- `TIMEOUT`, default 1000: maximum idle cycles between accepted bytes inside a frame; 0 disables the timeout.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  8  stream byte.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  loader accepts a byte this cycle; registered.
- `wr_en`  output  1  instruction-memory write strobe; registered.
- `wr_addr`  output  8  instruction word address.
- `wr_data`  output  16  instruction word.
- `cpu_hold`  output  1  drives the CPU reset; 1 = held.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  last frame loaded with a good checksum.
- `error`  output  1  last frame failed on checksum or timeout.

## Operation
- Accept: a byte is consumed at a rising edge when `in_valid && in_ready`. No other edge consumes a byte.
- Frame format: `0xA5` sync, count byte `C` (word count = C+1, range 1..256), then (C+1) words sent high byte first, then a checksum byte. The checksum is the XOR of `C` and every data byte.
- States: IDLE, COUNT, HI, LO, WRITE, CHK, DONE, ERR.
- IDLE, DONE and ERR consume every byte. On `0xA5` they go to COUNT, and DONE/ERR also clear `done` and `error` and set `cpu_hold=1`. Any other byte is discarded and the state is unchanged.
- COUNT: store `C`, seed the checksum with `C`, clear the 9-bit word counter and the 8-bit address, then go to HI.
- HI: latch the high byte, XOR it into the checksum, go to LO.
- LO: form the word, XOR the byte into the checksum, go to WRITE.
- WRITE: lasts exactly one cycle with `wr_en=1`, `wr_addr` = current address and `wr_data` = assembled word. `in_ready=0` during this cycle. At the next edge, the address and word counter increment. The state then goes to CHK if the counter reaches C+1, otherwise back to HI.
- CHK: if the byte equals the running checksum, go to DONE with `done=1` and `cpu_hold=0`. Otherwise go to ERR with `error=1` and `cpu_hold` left at 1.
- Memory writes already issued are never undone. After an error the CPU stays held until a good frame arrives.
- Address range: `wr_addr` spans 0..C, and 256 words end at 255 with no wrap. The word counter is 9 bits, so C=0xFF terminates correctly.
- Timeout: a counter runs in COUNT, HI, LO and CHK, clears on every accept, and does not count in WRITE. When it reaches `TIMEOUT` (nonzero), the state goes to ERR with `error=1`. A byte accepted on that same edge takes priority and clears the counter.
- A `0xA5` inside a frame is ordinary data, not a resync.
- `busy` is 1 in COUNT, HI, LO, WRITE and CHK.

## Timing
- Reset values: state IDLE, `in_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `cpu_hold=1`, `busy=0`, `done=0`, `error=0`. The checksum, counters and timeout counter all reset to 0.
- After `rst` falls, `in_ready` rises at the first rising edge.
- `in_ready` is registered: it is the complement of "next state is WRITE". It is 1 in every cycle except WRITE.
- If the low byte is accepted at edge k:
  - `wr_en`, `wr_addr` and `wr_data` are valid from edge k to edge k+1, and memory samples at k+1.
  - The next high byte can be accepted at k+2 at the earliest.
  - Sustained throughput is 2 bytes per 3 cycles.
- When the checksum byte is accepted at edge k, `done` or `error` and `cpu_hold` update at edge k, i.e. they are visible in the following cycle.
- `done` and `error` are never both 1.
- `rst` asserted mid-frame forces the reset values immediately. Partial memory contents are not defined.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs equal their reset values asynchronously. Release `rst` → `in_ready=1` after one edge, `cpu_hold=1`.
- Good frame `A5 01 12 34 AB CD 41` → writes addr0=0x1234 and addr1=0xABCD, one `wr_en` pulse each with `in_ready=0` during each pulse. Then `done=1`, `cpu_hold=0`, `busy=0`.
- Same frame with checksum `40` → both writes still occur, `error=1`, `done=0`, `cpu_hold=1`. Then resend the good frame → `done=1`, `error=0`, `cpu_hold=0`.
- Backpressure: hold `in_valid=1` through a WRITE cycle with the next byte presented → it is not consumed in WRITE and is accepted exactly once on the next edge. Random `in_valid` gaps produce the same memory image.
- Timeout with `TIMEOUT=16`: send `A5 00 12` then idle → `error=1` exactly 16 cycles after the last accept. Send `77` (discarded, still ERR), then `A5 00 99 88 11` → `done=1`.
- Full load C=0xFF with data = address replicated (0x0000, 0x0101, …) → 256 writes at addresses 0..255 with no wrap, then `done`. In a repeat run, assert `rst` after 10 words → immediate IDLE with `cpu_hold=1`.
